// File: rtl/afifo_rd_skid.sv
// afifo_rd_skid: circular skid buffer absorbing the one-cycle FIFO read latency
module afifo_rd_skid #(
    parameter int DATESIZE   = 8,
    parameter int SKID_DEPTH = 4
) (
    input  logic                        rclk,
    input  logic                        rrst_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic [DATESIZE-1:0]         din,
    input  logic                        pop,
    output logic [$clog2(SKID_DEPTH):0] occ,
    output logic                        valid,
    output logic [DATESIZE-1:0]         dout
);
    localparam int PW = $clog2(SKID_DEPTH);
    localparam int OW = PW + 1;
    logic [DATESIZE-1:0] mem [SKID_DEPTH];
    logic [PW-1:0]       wptr, rptr;
    assign valid = occ != '0;
    assign dout  = mem[rptr];
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
            occ  <= '0;
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            occ  <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) mem[wptr] <= din;
            wptr <= wptr + PW'(push);
            rptr <= rptr + PW'(pop);
            occ  <= occ + OW'(push) - OW'(pop);
        end
    end
endmodule

// File: rtl/afifo_rd_drain.sv
// afifo_rd_drain: read-side drain engine turning FIFO pops into a valid/ready stream
module afifo_rd_drain #(
    parameter int DATESIZE   = 8,
    parameter int SKID_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                rclk,
    input  logic                rrst_n,
    output logic                rinc,
    input  logic [DATESIZE-1:0] rdata,
    input  logic                rempty,
    input  logic                flush,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATESIZE-1:0] m_data,
    output logic                busy,
    output logic [CNT_W-1:0]    rd_cnt
);
    localparam int OW = $clog2(SKID_DEPTH) + 1;
    logic          infl, run;
    logic [OW-1:0] occ;
    logic [OW:0]   lvl;
    // run holds pops off while reset is asserted, even if the FIFO reports data
    assign lvl  = {1'b0, occ} + (OW+1)'(infl);
    assign rinc = run & ~rempty & ~flush & (lvl < (OW+1)'(SKID_DEPTH));
    assign busy = (occ != '0) | infl;
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            run    <= 1'b0;
            infl   <= 1'b0;
            rd_cnt <= '0;
        end else begin
            run    <= 1'b1;
            infl   <= rinc;
            rd_cnt <= rd_cnt + CNT_W'(m_valid & m_ready);
        end
    end
    afifo_rd_skid #(.DATESIZE(DATESIZE), .SKID_DEPTH(SKID_DEPTH)) u_skid (
        .rclk  (rclk),
        .rrst_n(rrst_n),
        .flush (flush),
        .push  (infl & ~flush),
        .din   (rdata),
        .pop   (m_valid & m_ready),
        .occ   (occ),
        .valid (m_valid),
        .dout  (m_data)
    );
endmodule
